// File: rtl/kmc_pkg.sv
// kmc_pkg
//   Shared definitions for the KMC11 control-RAM support logic.
//   - KMC_CRAM_DEPTH / KMC_CRAM_AW : CRAM size and address width
//   - KMC_CRAM_DW                  : microinstruction width carried by the loader
//   - kmcLDSTATE_t                 : CRAM loader sequencing states
package kmc_pkg;

  localparam int KMC_CRAM_DEPTH = 1024;
  localparam int KMC_CRAM_AW    = 10;
  localparam int KMC_CRAM_DW    = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ADDR,
    INST,
    WRITE,
    DONE
  } kmcLDSTATE_t;

endpackage

// File: rtl/kmc_cram_loader.sv
// kmc_cram_loader
//   Bootstrap writer for the KMC11 control RAM. Accepts 16-bit
//   microinstructions over a ready/valid stream and replays each one through
//   the sequencer maintenance path: load MNTADDR (SEL4), load MNTINST (SEL6),
//   then strobe the CRAM write. Holds the microprocessor stopped while busy.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     kmcINIT               KMC11 initialize, aborts a load in progress
//     ldSTART               single-cycle start request (ignored while busy)
//     ldBASE, ldCOUNT       first CRAM address, number of words (0..1024)
//     wordVALID, wordDATA   stream input
//     wordREADY             loader can take a word this cycle
//     ldDATA                value for the sequencer kmcDATAI mux
//     ldSEL4WRITE           load maintenance address strobe
//     ldSEL6WRITE           load maintenance instruction strobe
//     ldCRAMOUT, ldCRAMWR   CRAM maintenance-out enable and write strobe
//     ldHOLD, ldBUSY        clock-enable inhibit / load in progress
//     ldDONE, ldERR         sticky completion / error flags
//
//   Every output is a register updated alongside the state, so nothing on
//   the output side depends combinationally on an input.
module kmc_cram_loader
  import kmc_pkg::*;
#(
  parameter int CRAM_DEPTH = KMC_CRAM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kmcINIT,
  input  logic                   ldSTART,
  input  logic [KMC_CRAM_AW-1:0] ldBASE,
  input  logic [KMC_CRAM_AW:0]   ldCOUNT,
  input  logic                   wordVALID,
  input  logic [KMC_CRAM_DW-1:0] wordDATA,
  output logic                   wordREADY,
  output logic [35:0]            ldDATA,
  output logic                   ldSEL4WRITE,
  output logic                   ldSEL6WRITE,
  output logic                   ldCRAMOUT,
  output logic                   ldCRAMWR,
  output logic                   ldHOLD,
  output logic                   ldBUSY,
  output logic                   ldDONE,
  output logic                   ldERR
);

  localparam logic [KMC_CRAM_AW:0] DEPTH_LIM = CRAM_DEPTH[KMC_CRAM_AW:0];

  kmcLDSTATE_t            state;
  logic [KMC_CRAM_AW-1:0] addr;
  logic [KMC_CRAM_AW:0]   remain;
  logic [KMC_CRAM_DW-1:0] word;

  // Range check in 11 bits. With ldCOUNT <= 1024 and ldBASE <= 1023 the sum
  // cannot wrap, so the explicit count test covers every oversized request.
  logic [KMC_CRAM_AW:0] endAddr;
  logic                 rangeBad;

  assign endAddr  = {1'b0, ldBASE} + ldCOUNT;
  assign rangeBad = (ldCOUNT > DEPTH_LIM) || (endAddr > DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      word        <= '0;
      wordREADY   <= 1'b0;
      ldDATA      <= '0;
      ldSEL4WRITE <= 1'b0;
      ldSEL6WRITE <= 1'b0;
      ldCRAMOUT   <= 1'b0;
      ldCRAMWR    <= 1'b0;
      ldHOLD      <= 1'b0;
      ldBUSY      <= 1'b0;
      ldDONE      <= 1'b0;
      ldERR       <= 1'b0;
    end else begin
      // Strobes and data are single-cycle; each transition below re-asserts
      // only what the next state needs.
      ldSEL4WRITE <= 1'b0;
      ldSEL6WRITE <= 1'b0;
      ldCRAMOUT   <= 1'b0;
      ldCRAMWR    <= 1'b0;
      ldDATA      <= '0;

      if (kmcINIT && state != IDLE) begin
        // Abort: words already written stay written, no completion reported.
        state     <= IDLE;
        wordREADY <= 1'b0;
        ldHOLD    <= 1'b0;
        ldBUSY    <= 1'b0;
        ldERR     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ldSTART) begin
              addr   <= ldBASE;
              remain <= ldCOUNT;
              ldDONE <= 1'b0;
              ldERR  <= 1'b0;
              if (rangeBad) begin
                ldERR <= 1'b1;
              end else if (ldCOUNT == '0) begin
                state  <= DONE;
                ldHOLD <= 1'b1;
                ldBUSY <= 1'b1;
              end else begin
                state     <= FETCH;
                wordREADY <= 1'b1;
                ldHOLD    <= 1'b1;
                ldBUSY    <= 1'b1;
              end
            end
          end

          FETCH: begin
            if (wordVALID) begin
              word        <= wordDATA;
              state       <= ADDR;
              wordREADY   <= 1'b0;
              ldSEL4WRITE <= 1'b1;
              ldDATA      <= {26'b0, addr};
            end
          end

          ADDR: begin
            state       <= INST;
            ldSEL6WRITE <= 1'b1;
            ldDATA      <= {20'b0, word};
          end

          INST: begin
            state     <= WRITE;
            ldCRAMOUT <= 1'b1;
            ldCRAMWR  <= 1'b1;
          end

          WRITE: begin
            // addr wraps to 0 after the last word of a full image; harmless,
            // it is reloaded on the next start.
            addr   <= addr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == 11'd1) begin
              state <= DONE;
            end else begin
              state     <= FETCH;
              wordREADY <= 1'b1;
            end
          end

          DONE: begin
            state  <= IDLE;
            ldDONE <= 1'b1;
            ldHOLD <= 1'b0;
            ldBUSY <= 1'b0;
          end

          default: begin
            state     <= IDLE;
            wordREADY <= 1'b0;
            ldHOLD    <= 1'b0;
            ldBUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
